// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the lab FPU datapath (divider and multiplier).
// Provides field widths, the exponent bias, the canonical quiet NaN and the
// all-ones exponent. It also provides the operand-class enum, the divider
// state enum and the packed status-flag struct.
package fp32_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int          BIAS  = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } div_state_e;

  typedef struct packed {
    logic inf;
    logic nan;
    logic zero;
    logic overflow;
    logic underflow;
    logic div_by_zero;
  } fp_flags_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// Denormals (exp=0, mant!=0) are flushed to zero.
//   i_op    : 32-bit IEEE-754 single operand
//   o_class : FP_ZERO / FP_NORMAL / FP_INF / FP_NAN
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] i_op,
  output fp_class_e   o_class
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_unused_sign;

  assign w_exp         = i_op[30:23];
  assign w_man         = i_op[MAN_W-1:0];
  assign w_unused_sign = i_op[31];

  always_comb begin
    o_class = FP_NORMAL;
    if (w_exp == '0) begin
      o_class = FP_ZERO;
    end else if (w_exp == EXP_MAX) begin
      o_class = (w_man == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp32_divider.sv
// Iterative IEEE-754 single-precision divider, result = X / Y.
// Restoring division yields one quotient bit per cycle (25 cycles), followed
// by a normalisation cycle and a one-cycle done pulse. Special operands
// bypass the datapath and complete on the cycle after accept.
//   clk, reset_n : rising-edge clock, synchronous active-low reset
//   start        : request, accepted only while ready=1
//   X, Y         : dividend / divisor, sampled on the accept edge
//   ready        : high in IDLE only
//   done         : one-cycle pulse, result and flags valid on it
//   result       : quotient (truncated), held until the next result
//   inf, nan, zero, overflow, underflow, div_by_zero : status flags
module fp32_divider
  import fp32_pkg::*;
#(
  parameter int unsigned QBITS = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        inf,
  output logic        nan,
  output logic        zero,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  div_state_e        r_state;
  logic              r_ready;
  logic              r_done;
  logic [31:0]       r_result;
  fp_flags_t         r_flags;
  logic              r_sign;
  logic [EXP_W-1:0]  r_ex;
  logic [EXP_W-1:0]  r_ey;
  logic [24:0]       r_rem;
  logic [23:0]       r_b;
  logic [24:0]       r_q;
  logic [4:0]        r_cnt;

  fp_class_e         w_cx;
  fp_class_e         w_cy;
  logic              w_sign;
  logic              w_special;
  logic [31:0]       w_sp_result;
  fp_flags_t         w_sp_flags;

  logic              w_ge;
  logic [24:0]       w_rem_sel;
  logic [24:0]       w_rem_next;

  logic signed [9:0] w_e;
  logic signed [9:0] w_exp_n;
  logic [MAN_W-1:0]  w_mant;
  logic [31:0]       w_nm_result;
  fp_flags_t         w_nm_flags;

  fp32_classify u_class_x (.i_op(X), .o_class(w_cx));
  fp32_classify u_class_y (.i_op(Y), .o_class(w_cy));

  assign w_sign = X[31] ^ Y[31];

  // Special-case resolution, highest precedence first.
  always_comb begin
    w_special   = 1'b1;
    w_sp_result = '0;
    w_sp_flags  = '0;
    if (w_cx == FP_NAN || w_cy == FP_NAN ||
        (w_cx == FP_ZERO && w_cy == FP_ZERO) ||
        (w_cx == FP_INF  && w_cy == FP_INF)) begin
      w_sp_result    = QNAN;
      w_sp_flags.nan = 1'b1;
    end else if (w_cx == FP_NORMAL && w_cy == FP_ZERO) begin
      w_sp_result            = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_sp_flags.inf         = 1'b1;
      w_sp_flags.div_by_zero = 1'b1;
    end else if (w_cx == FP_INF) begin
      w_sp_result    = {w_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_sp_flags.inf = 1'b1;
    end else if (w_cx == FP_ZERO || w_cy == FP_INF) begin
      w_sp_result     = {w_sign, 31'h0};
      w_sp_flags.zero = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  // Restoring step: the remainder stays below B after each subtract, so the
  // left shift always fits the 25-bit remainder register.
  assign w_ge       = (r_rem >= {1'b0, r_b});
  assign w_rem_sel  = w_ge ? (r_rem - {1'b0, r_b}) : r_rem;
  assign w_rem_next = w_rem_sel << 1;

  // Exponent in a 10-bit signed datapath so range checks see no wrap.
  assign w_e     = $signed({2'b00, r_ex}) - $signed({2'b00, r_ey}) + $signed(10'(BIAS));
  assign w_exp_n = r_q[24] ? w_e : (w_e - 10'sd1);
  assign w_mant  = r_q[24] ? r_q[23:1] : r_q[22:0];

  always_comb begin
    w_nm_result = {r_sign, w_exp_n[7:0], w_mant};
    w_nm_flags  = '0;
    if (w_exp_n > 10'sd254) begin
      w_nm_result         = {r_sign, EXP_MAX, {MAN_W{1'b0}}};
      w_nm_flags.overflow = 1'b1;
    end else if (w_exp_n < 10'sd1) begin
      w_nm_result          = {r_sign, 31'h0};
      w_nm_flags.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ready <= 1'b0;
            r_sign  <= w_sign;
            r_ex    <= X[30:23];
            r_ey    <= Y[30:23];
            if (w_special) begin
              r_result <= w_sp_result;
              r_flags  <= w_sp_flags;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rem   <= {2'b01, X[MAN_W-1:0]};
              r_b     <= {1'b1, Y[MAN_W-1:0]};
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[23:0], w_ge};
          if (r_cnt == 5'(QBITS - 1)) begin
            r_state <= NORM;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        NORM: begin
          r_result <= w_nm_result;
          r_flags  <= w_nm_flags;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign result      = r_result;
  assign inf         = r_flags.inf;
  assign nan         = r_flags.nan;
  assign zero        = r_flags.zero;
  assign overflow    = r_flags.overflow;
  assign underflow   = r_flags.underflow;
  assign div_by_zero = r_flags.div_by_zero;

endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Iterative IEEE-754 single-precision divider (result = X / Y); the inverse-direction companion to the team's combinational FP32 multiplier.
- Restoring division produces one quotient bit per cycle, behind a start/ready/done handshake.
- Special-case flags are reported the same way the multiplier reports them, plus a divide-by-zero flag.
- Sits in the lab FPU datapath next to the multiplier.

Parameters:
- QBITS, 25, number of quotient bits generated. Fixed by the format; the parameter exists only for bench visibility.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when ready=1
- X  input  32  dividend, IEEE-754 single; sampled on the accept edge
- Y  input  32  divisor, IEEE-754 single; sampled on the accept edge
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; result and flags are valid on that cycle
- result  output  32  quotient; held until the next accept
- inf, nan, zero, overflow, underflow, div_by_zero  output  1 each  status flags; held with result

Behaviour:
- Reset: when reset_n=0 at a rising clk edge:
  - state=IDLE, ready=1, done=0, result=0, all flags=0.
  - Reset mid-operation aborts the division; no done pulse follows.
- States: IDLE -> DIVIDE -> NORM -> DONE -> IDLE. Special cases go IDLE -> DONE directly.
- IDLE:
  - On start=1, latch X and Y, classify both operands and go to DIVIDE (normal operands) or DONE (special case).
  - start while ready=0 is ignored and is not queued.
- Operand classification:
  - exp=0 means zero; denormals are flushed to zero.
  - exp=255 with mant=0 means inf.
  - exp=255 with mant!=0 means NaN.
  - Anything else is normal.
- Special-case precedence, highest first:
  - NaN: either operand NaN, 0/0, or inf/inf. result=32'h7FC00000, nan=1.
  - Divide by zero: normal/0. result={s,8'hFF,23'h0}, inf=1, div_by_zero=1.
  - Infinity: inf/normal or inf/0. result={s,8'hFF,0}, inf=1.
  - Zero: 0/normal or normal/inf or 0/inf. result={s,31'h0}, zero=1.
  - s = X[31]^Y[31] in every case.
- DIVIDE:
  - A={1,Mx} and B={1,My}, both 24 bits.
  - Restoring division computes Q=floor(A*2^24/B). Q is 25 bits and lies in [2^23, 2^25).
  - One bit per cycle, MSB first, exactly 25 cycles. The partial remainder is 25 bits; the remainder is discarded.
- Exponent: E = Ex - Ey + 127, computed in a 10-bit signed datapath (no wrap).
- NORM:
  - If Q[24]=1: mant=Q[23:1], exp=E.
  - Else: mant=Q[22:0], exp=E-1.
  - Truncation only, no rounding (same as the multiplier).
- Range checks after normalisation:
  - exp > 254: result={s,8'hFF,0}, overflow=1.
  - exp < 1: result={s,31'h0}, underflow=1.
  - Otherwise: result={s,exp[7:0],mant}, all flags 0.
- DONE: done=1 for one cycle, then IDLE with ready=1. A new start may be accepted on the cycle after done.
- Latency, with accept edge at cycle T:
  - Normal operands: done at T+27.
  - Special cases: done at T+1.
- Flags are one-hot or all zero, except that inf and div_by_zero are high together.

Decomposition:
- Shared package fp32_pkg:
  - Field widths (EXP_W=8, MAN_W=23) and BIAS=127.
  - Constants QNAN=32'h7FC00000 and EXP_MAX=8'hFF.
  - Operand-class enum {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN}.
  - State enum {IDLE, DIVIDE, NORM, DONE}.
  - The package is reusable by the multiplier.
- Sub-module fp32_classify: combinational, 32-bit in, class enum out. Instantiated twice, once per operand.

Test Plan:
- 6.0/2.0: X=40C00000, Y=40000000 -> result=40400000 exactly at T+27, flags 0, ready low T+1..T+27. Repeat with -6.0: X=C0C00000 -> C0400000.
- 1.0/3.0: X=3F800000, Y=40400000 -> result=3EAAAAAA (truncated, not rounded).
- Specials, each with done at T+1:
  - 3F800000/00000000 -> 7F800000, inf=1, div_by_zero=1.
  - 0/0 -> 7FC00000, nan=1.
  - 7F800000/7F800000 -> 7FC00000, nan=1.
  - 3F800000/7F800000 -> 00000000, zero=1.
- Range:
  - 7F000000/00800000 -> 7F800000, overflow=1.
  - 00800000/7F000000 -> 00000000, underflow=1.
  - Mantissa-normalisation path: 3F800000/3FC00000 -> 3F2AAAAA (Q[24]=0).
- Handshake and reset:
  - start asserted while busy -> ignored; only one done pulse.
  - Back-to-back start on the cycle after done -> accepted.
  - reset_n=0 at T+10 -> IDLE, ready=1, result=0, no done pulse.
